// File: rtl/top_uart.sv
// Memory-mapped 8N1 UART: CTRL/TXD/RXD register bank with registered LED readback.
// Optional UART_RX_SYNC_EN adds a two-flop synchronizer on rx ahead of the receiver.
module top_uart #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk_100m_i,
    input  logic       rst_i,
    input  logic [7:0] entrada_i,
    input  logic       reg_sel_i,
    input  logic       wr_i,
    input  logic       addr_i,
    input  logic       rx,
    output logic [7:0] leds_o,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_HALF = CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    // No handshake on the register port: wr_i is a level write strobe taken on
    // every rising edge, and reads always return the selected register one cycle later.
    logic [2:0]    ctrl, ctrl_d;
    logic [7:0]    txd, txd_d, rxd, rxd_d;

    uart_state_t   tx_state, tx_state_d;
    logic [CW-1:0] tx_cnt, tx_cnt_d;
    logic [3:0]    tx_bit, tx_bit_d;
    logic [7:0]    tx_shift, tx_shift_d;
    logic          tx_d, send_clr;

    uart_state_t   rx_state, rx_state_d;
    logic [CW-1:0] rx_cnt, rx_cnt_d;
    logic [3:0]    rx_bit, rx_bit_d;
    logic [7:0]    rx_shift, rx_shift_d;
    logic          rx_s, rx_ok, rx_ferr;

`ifdef UART_RX_SYNC_EN
    logic rx_meta;
    always_ff @(posedge clk_100m_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end
`else
    always_ff @(posedge clk_100m_i) begin
        if (rst_i) rx_s <= 1'b1;
        else       rx_s <= rx;
    end
`endif

    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_bit_d   = tx_bit;
        tx_shift_d = tx_shift;
        send_clr   = 1'b0;
        case (tx_state)
            S_IDLE: begin
                if (ctrl[0]) begin
                    tx_shift_d = txd;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift[7:1]};
                    if (tx_bit == 4'd7) begin
                        tx_bit_d   = '0;
                        tx_state_d = S_STOP;
                    end else begin
                        tx_bit_d = tx_bit + 4'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = S_IDLE;
                    send_clr   = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt + 1'b1;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        // Pin value follows the next state so tx is a clean flop output.
        case (tx_state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = tx_shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt;
        rx_bit_d   = rx_bit;
        rx_shift_d = rx_shift;
        rx_ok      = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (!rx_s) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_cnt == BIT_HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift[7:1]};
                    if (rx_bit == 4'd7) begin
                        rx_bit_d   = '0;
                        rx_state_d = S_STOP;
                    end else begin
                        rx_bit_d = rx_bit + 4'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_IDLE;
                    rx_ok      = rx_s;
                    rx_ferr    = !rx_s;
                end else begin
                    rx_cnt_d = rx_cnt + 1'b1;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // Priority: hardware SEND clear < software write < hardware RX flags.
    always_comb begin
        ctrl_d = ctrl;
        txd_d  = txd;
        rxd_d  = rxd;
        if (send_clr) ctrl_d[0] = 1'b0;
        if (wr_i && !reg_sel_i) ctrl_d = entrada_i[2:0];
        if (wr_i && reg_sel_i && !addr_i) txd_d = entrada_i;
        if (rx_ok) begin
            rxd_d     = rx_shift;
            ctrl_d[1] = 1'b1;
            ctrl_d[2] = 1'b0;
        end
        if (rx_ferr) ctrl_d[2] = 1'b1;
    end

    always_ff @(posedge clk_100m_i) begin
        if (rst_i) begin
            ctrl     <= '0;
            txd      <= '0;
            rxd      <= '0;
            leds_o   <= '0;
            tx       <= 1'b1;
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            ctrl     <= ctrl_d;
            txd      <= txd_d;
            rxd      <= rxd_d;
            leds_o   <= reg_sel_i ? (addr_i ? rxd : txd) : {5'b0, ctrl};
            tx       <= tx_d;
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_shift <= tx_shift_d;
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_bit   <= rx_bit_d;
            rx_shift <= rx_shift_d;
        end
    end

endmodule

// File: tb/tb_top_uart.sv
// Directed bench for top_uart with a shortened bit time; tx bits checked at mid-bit.
module tb_top_uart;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] entrada = '0;
    logic       reg_sel = 1'b0;
    logic       wr = 1'b0;
    logic       addr = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] leds;
    logic       tx;

    int n_vec = 0;
    int n_err = 0;
    logic [0:0] exp_q[$];

    top_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clk_100m_i(clk),
        .rst_i     (rst),
        .entrada_i (entrada),
        .reg_sel_i (reg_sel),
        .wr_i      (wr),
        .addr_i    (addr),
        .rx        (rx),
        .leds_o    (leds),
        .tx        (tx)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic sel, input logic a, input logic [7:0] d);
        @(negedge clk);
        reg_sel = sel; addr = a; entrada = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic rd_reg(input logic sel, input logic a, output logic [7:0] v);
        @(negedge clk);
        reg_sel = sel; addr = a; wr = 1'b0;
        @(negedge clk);
        v = leds;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    // Sends 0x25 (TXD must hold it) and checks the waveform; optional mid-frame TXD poke.
    task automatic tx_frame(input logic poke);
        int waitc;
        int low_cnt;
        int zeros;
        logic [8:0] pat;
        logic [0:0] e;
        logic [7:0] v;
        pat = 9'b1_0010_0101;
        exp_q.delete();
        for (int i = 0; i < 9; i++) exp_q.push_back(pat[i]);
        wr_reg(1'b0, 1'b0, 8'h01);
        waitc = 0;
        while (tx !== 1'b0 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check("tx_start_seen", 16'(waitc < 50), 16'd1);
        if (waitc >= 50) return;
        low_cnt = 0;
        while (tx === 1'b0 && low_cnt < 1000) begin
            low_cnt++;
            @(negedge clk);
        end
        check("tx_start_len", 16'(low_cnt), 16'(CPB));
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            e = exp_q.pop_front();
            check($sformatf("tx_bit%0d", k), 16'(tx), 16'(e));
            if (k == 1 && poke) begin
                reg_sel = 1'b1; addr = 1'b0; entrada = 8'hFF; wr = 1'b1;
                @(negedge clk);
                wr = 1'b0;
                repeat (CPB - 1) @(negedge clk);
            end else if (k < 8) begin
                repeat (CPB) @(negedge clk);
            end
        end
        repeat (CPB) @(negedge clk);
        rd_reg(1'b0, 1'b0, v);
        check("send_cleared", 16'(v[0]), 16'd0);
        zeros = 0;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) zeros++;
        end
        check("tx_no_resend", 16'(zeros), 16'd0);
    endtask

    initial begin
        logic [7:0] v;
        int waitc;

        // reset
        rst = 1'b1;
        repeat (200) @(negedge clk);
        check("rst_tx", 16'(tx), 16'd1);
        check("rst_leds", 16'(leds), 16'h00);
        rst = 1'b0;
        rd_reg(1'b0, 1'b0, v); check("rst_ctrl", 16'(v), 16'h00);
        rd_reg(1'b1, 1'b1, v); check("rst_rxd", 16'(v), 16'h00);

        // TXD write/readback, then a frame with a TXD change mid-frame
        wr_reg(1'b1, 1'b0, 8'h25);
        rd_reg(1'b1, 1'b0, v); check("txd_rd", 16'(v), 16'h25);
        tx_frame(1'b1);
        rd_reg(1'b1, 1'b0, v); check("txd_poked", 16'(v), 16'hFF);
        rd_reg(1'b0, 1'b0, v); check("ctrl_after_tx", 16'(v), 16'h00);

        // receive 0xAB
        rx_send(8'hAB, 1'b1);
        rd_reg(1'b1, 1'b1, v); check("rxd_ab", 16'(v), 16'hAB);
        rd_reg(1'b0, 1'b0, v); check("ctrl_rxnew", 16'(v), 16'h02);

        // false start
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        rd_reg(1'b1, 1'b1, v); check("rxd_false", 16'(v), 16'hAB);
        rd_reg(1'b0, 1'b0, v); check("ctrl_false", 16'(v), 16'h02);

        // RXD is read-only
        wr_reg(1'b1, 1'b1, 8'h77);
        rd_reg(1'b1, 1'b1, v); check("rxd_ro", 16'(v), 16'hAB);

        // framing error then a good frame
        rx_send(8'h5A, 1'b0);
        rd_reg(1'b1, 1'b1, v); check("rxd_ferr", 16'(v), 16'hAB);
        rd_reg(1'b0, 1'b0, v); check("ctrl_ferr", 16'(v), 16'h06);
        rx_send(8'h3C, 1'b1);
        rd_reg(1'b1, 1'b1, v); check("rxd_3c", 16'(v), 16'h3C);
        rd_reg(1'b0, 1'b0, v); check("ctrl_3c", 16'(v), 16'h02);

        // CTRL writes: only bits 2:0 stored
        wr_reg(1'b0, 1'b0, 8'hFE);
        rd_reg(1'b0, 1'b0, v); check("ctrl_fe", 16'(v), 16'h06);
        wr_reg(1'b0, 1'b0, 8'h00);
        rd_reg(1'b0, 1'b0, v); check("ctrl_clr", 16'(v), 16'h00);

        // reset in the middle of a TX frame
        wr_reg(1'b1, 1'b0, 8'h25);
        wr_reg(1'b0, 1'b0, 8'h01);
        waitc = 0;
        while (tx !== 1'b0 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check("rst_mid_start", 16'(waitc < 50), 16'd1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tx", 16'(tx), 16'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rd_reg(1'b0, 1'b0, v); check("rst_mid_ctrl", 16'(v), 16'h00);
        rd_reg(1'b1, 1'b0, v); check("rst_mid_txd", 16'(v), 16'h00);
        check("rst_mid_idle", 16'(tx), 16'd1);

        // simultaneous TX 0x25 and RX 0xAB
        wr_reg(1'b1, 1'b0, 8'h25);
        fork
            tx_frame(1'b0);
            rx_send(8'hAB, 1'b1);
        join
        rd_reg(1'b1, 1'b1, v); check("dual_rxd", 16'(v), 16'hAB);
        rd_reg(1'b0, 1'b0, v); check("dual_ctrl", 16'(v), 16'h02);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
